path_delay_meter: RTL and testbench

- Launch/capture controller that sits directly in front of, and directly behind, a single-path delay chain.
- Drives the chain input with a controlled 0->1 transition and synchronises the chain output back into the clock domain.
- Counts clock cycles from launch to arrival, repeats over 2^TRIALS_LOG2 trials and reports the sum and the average.
- Comparing the result against a golden value flags inserted delay (Trojan) on the path.

---
 rtl/path_meas_pkg.sv | 26 ++
 rtl/path_sync.sv | 24 ++
 rtl/path_delay_meter.sv | 154 +++++++++++++++
 tb/tb_path_delay_meter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_meas_pkg.sv
// Shared types, default parameters and width helper for the
// path delay meter.
package path_meas_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREP    = 3'd1,
        LAUNCH  = 3'd2,
        MEASURE = 3'd3,
        ACCUM   = 3'd4,
        FINISH  = 3'd5
    } measState_t;

    localparam int DEF_CNT_W         = 16;
    localparam int DEF_TIMEOUT       = 1023;
    localparam int DEF_TRIALS_LOG2   = 3;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_SETTLE_CYCLES = 4;

    // Sum of 2^trialsLog2 counts of cntW bits never needs more bits.
    function automatic int resultWidth(input int cntW,
                                       input int trialsLog2);
        return cntW + trialsLog2;
    endfunction

endpackage

// File: rtl/path_sync.sv
// Multi-flop synchroniser with async active-low clear.
// Ports: clk, rst_n, asyncIn (any domain), syncOut (clk domain).
module path_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic asyncIn,
    output logic syncOut
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], asyncIn};
        end
    end

    assign syncOut = chain[STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// Launch/capture controller measuring clock cycles through a delay path.
// Ports: clk, rst_n, start -> path_launch out, path_capture in (async),
// busy, done, timeout_err, delay_sum, delay_avg, trial_idx.
module path_delay_meter
    import path_meas_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int TIMEOUT       = DEF_TIMEOUT,
    parameter int TRIALS_LOG2   = DEF_TRIALS_LOG2,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   path_launch,
    input  logic                   path_capture,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic [resultWidth(CNT_W, TRIALS_LOG2)-1:0] delay_sum,
    output logic [CNT_W-1:0]       delay_avg,
    output logic [TRIALS_LOG2-1:0] trial_idx
);

    localparam int SUM_W = resultWidth(CNT_W, TRIALS_LOG2);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] TIMEOUT_V   = CNT_W'(TIMEOUT);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TRIALS_LOG2-1:0] LAST_TRIAL = '1;

    measState_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] sample;
    logic [SET_W-1:0] settleCnt;
    logic             capS;
    logic             settled;
    logic             abortNow;
    logic [SUM_W-1:0] newSum;
    logic [SUM_W-1:0] newAvg;
    logic [SUM_W-1:0] partAvg;

    path_sync #(
        .STAGES (SYNC_STAGES)
    ) uSync (
        .clk     (clk),
        .rst_n   (rst_n),
        .asyncIn (path_capture),
        .syncOut (capS)
    );

    assign busy = (state != IDLE);

    // Settling wins over timeout when both land on the same edge.
    assign settled = !capS && (settleCnt == SETTLE_LAST);

    always_comb begin
        abortNow = 1'b0;
        if (state == PREP && !settled && cnt == TIMEOUT_V) begin
            abortNow = 1'b1;
        end
        if (state == MEASURE && !capS && cnt == TIMEOUT_V) begin
            abortNow = 1'b1;
        end
    end

    assign newSum  = delay_sum + SUM_W'(sample);
    assign newAvg  = newSum >> TRIALS_LOG2;
    assign partAvg = delay_sum >> TRIALS_LOG2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            path_launch <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            delay_sum   <= '0;
            delay_avg   <= '0;
            trial_idx   <= '0;
            cnt         <= '0;
            sample      <= '0;
            settleCnt   <= '0;
        end else begin
            done <= 1'b0;
            if (abortNow) begin
                path_launch <= 1'b0;
                timeout_err <= 1'b1;
                done        <= 1'b1;
                delay_avg   <= partAvg[CNT_W-1:0];
                state       <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            delay_sum   <= '0;
                            timeout_err <= 1'b0;
                            trial_idx   <= '0;
                            cnt         <= '0;
                            settleCnt   <= '0;
                            state       <= PREP;
                        end
                    end
                    PREP: begin
                        path_launch <= 1'b0;
                        if (settled) begin
                            cnt   <= '0;
                            state <= LAUNCH;
                        end else begin
                            cnt       <= cnt + 1'b1;
                            settleCnt <= capS ? '0 : settleCnt + 1'b1;
                        end
                    end
                    LAUNCH: begin
                        path_launch <= 1'b1;
                        cnt         <= '0;
                        state       <= MEASURE;
                    end
                    MEASURE: begin
                        // cnt already holds the edges since launch up to
                        // the edge at which capS rose.
                        if (capS) begin
                            sample      <= cnt;
                            path_launch <= 1'b0;
                            state       <= ACCUM;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ACCUM: begin
                        delay_sum <= newSum;
                        cnt       <= '0;
                        settleCnt <= '0;
                        if (trial_idx == LAST_TRIAL) begin
                            delay_avg <= newAvg[CNT_W-1:0];
                            done      <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            trial_idx <= trial_idx + 1'b1;
                            state     <= PREP;
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_path_delay_meter.sv
// Directed bench for path_delay_meter: loopback, modelled delay,
// stuck capture, mid-run reset and ignored starts.
module tb_path_delay_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        path_launch;
    logic        path_capture;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [18:0] delay_sum;
    logic [15:0] delay_avg;
    logic [2:0]  trial_idx;

    int nChecks = 0;
    int nFail = 0;
    int mode = 0;
    int doneCount = 0;
    int launchCount = 0;
    logic [4:0] dly;

    path_delay_meter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .path_launch  (path_launch),
        .path_capture (path_capture),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err),
        .delay_sum    (delay_sum),
        .delay_avg    (delay_avg),
        .trial_idx    (trial_idx)
    );

    always #5 clk = ~clk;

    // Five-cycle delay line model of the path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly <= '0;
        else        dly <= {dly[3:0], path_launch};
    end

    always_comb begin
        case (mode)
            0:       path_capture = path_launch;
            1:       path_capture = dly[4];
            2:       path_capture = 1'b0;
            default: path_capture = 1'b1;
        endcase
    end

    always @(posedge clk) begin
        if (done === 1'b1) doneCount <= doneCount + 1;
        if (path_launch === 1'b1) launchCount <= launchCount + 1;
    end

    task automatic pulseStart();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic waitDone(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nChecks++;
        if (path_launch !== 1'b0) begin
            nFail++; $display("FAIL reset_launch: got %b want 0", path_launch);
        end
        nChecks++;
        if (busy !== 1'b0) begin
            nFail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        nChecks++;
        if (done !== 1'b0) begin
            nFail++; $display("FAIL reset_done: got %b want 0", done);
        end
        nChecks++;
        if (timeout_err !== 1'b0) begin
            nFail++; $display("FAIL reset_err: got %b want 0", timeout_err);
        end
        nChecks++;
        if (delay_sum !== 19'd0) begin
            nFail++; $display("FAIL reset_sum: got %0d want 0", delay_sum);
        end
        nChecks++;
        if (delay_avg !== 16'd0) begin
            nFail++; $display("FAIL reset_avg: got %0d want 0", delay_avg);
        end
        nChecks++;
        if (trial_idx !== 3'd0) begin
            nFail++; $display("FAIL reset_idx: got %0d want 0", trial_idx);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        bit ok;
        int d0;
        mode = 0;
        repeat (4) @(negedge clk);
        d0 = doneCount;
        pulseStart();
        nChecks++;
        if (busy !== 1'b1) begin
            nFail++; $display("FAIL loop_busy: got %b want 1", busy);
        end
        waitDone(ok);
        nChecks++;
        if (!ok) begin
            nFail++; $display("FAIL loop_wait: got no done want done");
        end
        nChecks++;
        if (delay_sum !== 19'd16) begin
            nFail++; $display("FAIL loop_sum: got %0d want 16", delay_sum);
        end
        nChecks++;
        if (delay_avg !== 16'd2) begin
            nFail++; $display("FAIL loop_avg: got %0d want 2", delay_avg);
        end
        nChecks++;
        if (timeout_err !== 1'b0) begin
            nFail++; $display("FAIL loop_err: got %b want 0", timeout_err);
        end
        nChecks++;
        if (trial_idx !== 3'd7) begin
            nFail++; $display("FAIL loop_idx: got %0d want 7", trial_idx);
        end
        @(negedge clk);
        nChecks++;
        if (done !== 1'b0) begin
            nFail++; $display("FAIL loop_pulse: got %b want 0", done);
        end
        nChecks++;
        if (busy !== 1'b0) begin
            nFail++; $display("FAIL loop_idle: got %b want 0", busy);
        end
        repeat (3) @(negedge clk);
        nChecks++;
        if (doneCount !== d0 + 1) begin
            nFail++; $display("FAIL loop_ndone: got %0d want %0d", doneCount - d0, 1);
        end
    endtask

    task automatic test_delay5();
        bit ok;
        mode = 1;
        repeat (4) @(negedge clk);
        pulseStart();
        waitDone(ok);
        nChecks++;
        if (!ok) begin
            nFail++; $display("FAIL d5_wait: got no done want done");
        end
        nChecks++;
        if (delay_sum !== 19'd56) begin
            nFail++; $display("FAIL d5_sum: got %0d want 56", delay_sum);
        end
        nChecks++;
        if (delay_avg !== 16'd7) begin
            nFail++; $display("FAIL d5_avg: got %0d want 7", delay_avg);
        end
        nChecks++;
        if (timeout_err !== 1'b0) begin
            nFail++; $display("FAIL d5_err: got %b want 0", timeout_err);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_tie0();
        bit ok;
        int lc0;
        mode = 2;
        repeat (4) @(negedge clk);
        lc0 = launchCount;
        pulseStart();
        waitDone(ok);
        nChecks++;
        if (!ok) begin
            nFail++; $display("FAIL t0_wait: got no done want done");
        end
        nChecks++;
        if (timeout_err !== 1'b1) begin
            nFail++; $display("FAIL t0_err: got %b want 1", timeout_err);
        end
        nChecks++;
        if (delay_sum !== 19'd0) begin
            nFail++; $display("FAIL t0_sum: got %0d want 0", delay_sum);
        end
        nChecks++;
        if (delay_avg !== 16'd0) begin
            nFail++; $display("FAIL t0_avg: got %0d want 0", delay_avg);
        end
        nChecks++;
        if (path_launch !== 1'b0) begin
            nFail++; $display("FAIL t0_launch: got %b want 0", path_launch);
        end
        nChecks++;
        if (launchCount - lc0 < 1000) begin
            nFail++; $display("FAIL t0_hold: got %0d want >=1000", launchCount - lc0);
        end
        nChecks++;
        if (trial_idx !== 3'd0) begin
            nFail++; $display("FAIL t0_idx: got %0d want 0", trial_idx);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_tie1();
        bit ok;
        int lc0;
        mode = 3;
        repeat (6) @(negedge clk);
        lc0 = launchCount;
        pulseStart();
        waitDone(ok);
        nChecks++;
        if (!ok) begin
            nFail++; $display("FAIL t1_wait: got no done want done");
        end
        nChecks++;
        if (timeout_err !== 1'b1) begin
            nFail++; $display("FAIL t1_err: got %b want 1", timeout_err);
        end
        nChecks++;
        if (launchCount !== lc0) begin
            nFail++; $display("FAIL t1_nolaunch: got %0d want 0", launchCount - lc0);
        end
        nChecks++;
        if (delay_sum !== 19'd0) begin
            nFail++; $display("FAIL t1_sum: got %0d want 0", delay_sum);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        mode = 1;
        repeat (4) @(negedge clk);
        pulseStart();
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            if (trial_idx === 3'd3 && path_launch === 1'b1) hit = 1'b1;
        end
        nChecks++;
        if (!hit) begin
            nFail++; $display("FAIL mid_reach: got no trial3 launch want launch");
        end
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (path_launch !== 1'b0) begin
            nFail++; $display("FAIL mid_launch: got %b want 0", path_launch);
        end
        nChecks++;
        if (busy !== 1'b0) begin
            nFail++; $display("FAIL mid_busy: got %b want 0", busy);
        end
        nChecks++;
        if (delay_sum !== 19'd0) begin
            nFail++; $display("FAIL mid_sum: got %0d want 0", delay_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pulseStart();
        waitDone(ok);
        nChecks++;
        if (!ok) begin
            nFail++; $display("FAIL mid_wait: got no done want done");
        end
        nChecks++;
        if (delay_avg !== 16'd7) begin
            nFail++; $display("FAIL mid_avg: got %0d want 7", delay_avg);
        end
        nChecks++;
        if (delay_sum !== 19'd56) begin
            nFail++; $display("FAIL mid_sum2: got %0d want 56", delay_sum);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d0;
        mode = 0;
        repeat (6) @(negedge clk);
        d0 = doneCount;
        pulseStart();
        repeat (3) @(negedge clk);
        pulseStart();
        repeat (40) @(negedge clk);
        pulseStart();
        waitDone(ok);
        nChecks++;
        if (!ok) begin
            nFail++; $display("FAIL b2b_wait: got no done want done");
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nChecks++;
        if (busy !== 1'b0) begin
            nFail++; $display("FAIL b2b_donestart: got busy %b want 0", busy);
        end
        repeat (60) @(negedge clk);
        nChecks++;
        if (busy !== 1'b0) begin
            nFail++; $display("FAIL b2b_idle: got %b want 0", busy);
        end
        nChecks++;
        if (doneCount !== d0 + 1) begin
            nFail++; $display("FAIL b2b_ndone: got %0d want 1", doneCount - d0);
        end
        nChecks++;
        if (delay_sum !== 19'd16) begin
            nFail++; $display("FAIL b2b_sum: got %0d want 16", delay_sum);
        end
        nChecks++;
        if (timeout_err !== 1'b0) begin
            nFail++; $display("FAIL b2b_err: got %b want 0", timeout_err);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_delay5();
        test_tie0();
        test_tie1();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

endmodule
